// File: rtl/bus_arbiter4_pkg.sv
// Shared definitions for the four-way round-robin output arbiter: sizes,
// FSM state encodings and the pointer reset value.
package bus_arbiter4_pkg;

  localparam int NREQ  = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  // Pointer starts at the last index so requester 0 has first priority.
  localparam logic [SEL_W-1:0] LAST_RST = 2'b11;

  function automatic logic [NREQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    return NREQ'(1) << idx;
  endfunction

endpackage

// File: rtl/bus_arbiter4_rr_pick4.sv
// Combinational round-robin picker: scans the candidate mask starting one
// position after the previous winner and returns the first set bit.
module rr_pick4
  import bus_arbiter4_pkg::*;
(
  input  logic [NREQ-1:0]  cand,
  input  logic [SEL_W-1:0] last,
  output logic             gnt_v,
  output logic [SEL_W-1:0] gnt_idx
);

  always_comb begin
    logic [SEL_W-1:0] idx;
    // NOTE: every variable gets a default before any conditional write so no latch is inferred.
    gnt_v   = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    // Offsets 1..NREQ wrap modulo NREQ; the last offset revisits the previous winner.
    for (int k = 1; k <= NREQ; k++) begin
      idx = last + SEL_W'(k);
      if (!gnt_v && cand[idx]) begin
        gnt_v   = 1'b1;
        gnt_idx = idx;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter4.sv
// Four-requester round-robin arbiter feeding one registered valid/ready output
// channel; a transfer can re-grant and capture in the same edge.
module bus_arbiter4
  import bus_arbiter4_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  input  logic [DATA_W-1:0] data2,
  input  logic [DATA_W-1:0] data3,
  output logic [NREQ-1:0]   ack,
  output logic [SEL_W-1:0]  sel,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy
);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   last_q, last_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [DATA_W-1:0]  data_mux;
  logic [NREQ-1:0]    cand;
  logic               gnt_v;
  logic [SEL_W-1:0]   gnt_idx;
  logic               grant;

  // A requester acked this cycle still shows its old word, so exclude it.
  assign cand  = req & ~ack;
  assign grant = gnt_v & ((state_q == ST_IDLE) | out_ready);

  rr_pick4 u_pick (
    .cand    (cand),
    .last    (last_q),
    .gnt_v   (gnt_v),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    data_mux = data0;
    case (gnt_idx)
      2'd0:    data_mux = data0;
      2'd1:    data_mux = data1;
      2'd2:    data_mux = data2;
      default: data_mux = data3;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (gnt_v) state_d = ST_HOLD;
      ST_HOLD: if (out_ready && !gnt_v) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs; reset suppresses ack so a discarded word is never reported as accepted.
  always_comb begin
    out_valid = (state_q == ST_HOLD);
    busy      = out_valid;
    ack       = onehot(sel_q) & {NREQ{out_valid & out_ready & ~reset}};
  end

  always_comb begin
    sel_d  = sel_q;
    last_d = last_q;
    data_d = data_q;
    if (grant) begin
      sel_d  = gnt_idx;
      last_d = gnt_idx;
      data_d = data_mux;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q  <= '0;
      last_q <= LAST_RST;
      data_q <= '0;
    end else begin
      sel_q  <= sel_d;
      last_q <= last_d;
      data_q <= data_d;
    end
  end

  assign sel      = sel_q;
  assign out_data = data_q;

endmodule

// File: tb/tb_bus_arbiter4.sv
// Directed scenarios plus a randomized run against a queue-free behavioural
// model of the round-robin valid/ready arbiter.
module tb_bus_arbiter4;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] d [4];
  logic [3:0]  ack;
  logic [1:0]  sel;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic        busy;

  int total = 0;
  int bad   = 0;

  bus_arbiter4 #(.DATA_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .data0     (d[0]),
    .data1     (d[1]),
    .data2     (d[2]),
    .data3     (d[3]),
    .ack       (ack),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Inputs change at the falling edge; outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rand_inputs();
    req       = 4'($urandom);
    out_ready = 1'($urandom);
    for (int i = 0; i < 4; i++) d[i] = $urandom;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rand_inputs();
    tick();
    tick();
    reset     = 1'b0;
    req       = 4'b0000;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rand_inputs();
    tick();
    rand_inputs();
    tick();
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
    total++; if (ack !== 4'b0000) begin bad++; $display("FAIL reset_ack got=%b exp=0000", ack); end
    total++; if (sel !== 2'b00) begin bad++; $display("FAIL reset_sel got=%0d exp=0", sel); end
    total++; if (out_data !== 32'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", out_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    reset = 1'b0; req = 4'b0000; out_ready = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0001; d[0] = 32'hDEADBEEF; out_ready = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_latency got=%0b exp=0", out_valid); end
    tick();
    for (int i = 0; i < 6; i++) begin
      #1;
      total++; if (out_valid !== (i % 2 == 0)) begin bad++; $display("FAIL single_valid[%0d] got=%0b exp=%0b", i, out_valid, (i % 2 == 0)); end
      total++; if (out_data !== 32'hDEADBEEF) begin bad++; $display("FAIL single_data[%0d] got=%h exp=deadbeef", i, out_data); end
      total++; if (ack !== ((i % 2 == 0) ? 4'b0001 : 4'b0000)) begin bad++; $display("FAIL single_ack[%0d] got=%b", i, ack); end
      tick();
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_all();
    do_reset();
    req = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) d[i] = 32'(i + 1);
    tick();
    for (int k = 0; k < 6; k++) begin
      #1;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL all_valid[%0d] got=%0b exp=1", k, out_valid); end
      total++; if (sel !== 2'(k % 4)) begin bad++; $display("FAIL all_sel[%0d] got=%0d exp=%0d", k, sel, k % 4); end
      total++; if (out_data !== 32'(k % 4 + 1)) begin bad++; $display("FAIL all_data[%0d] got=%0d exp=%0d", k, out_data, k % 4 + 1); end
      total++; if (ack !== 4'(1 << (k % 4))) begin bad++; $display("FAIL all_ack[%0d] got=%b", k, ack); end
      tick();
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    req = 4'b0100; d[2] = 32'h1234; out_ready = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      req  = 4'($urandom);
      d[2] = $urandom;
      #1;
      total++; if (out_data !== 32'h1234) begin bad++; $display("FAIL bp_data[%0d] got=%h exp=1234", i, out_data); end
      total++; if (ack !== 4'b0000) begin bad++; $display("FAIL bp_ack[%0d] got=%b exp=0000", i, ack); end
      total++; if (out_valid !== 1'b1 || sel !== 2'd2) begin bad++; $display("FAIL bp_hold[%0d] valid=%0b sel=%0d exp 1/2", i, out_valid, sel); end
      tick();
    end
    req = 4'b0000; out_ready = 1'b1;
    #1;
    total++; if (ack !== 4'b0100) begin bad++; $display("FAIL bp_release_ack got=%b exp=0100", ack); end
    tick();
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_idle got=%0b exp=0", out_valid); end
  endtask

  task automatic test_drop();
    do_reset();
    req = 4'b0010; d[1] = 32'hCAFE0001; out_ready = 1'b0;
    tick();
    req = 4'b0000;
    #1;
    total++; if (out_valid !== 1'b1 || sel !== 2'd1) begin bad++; $display("FAIL drop_grant valid=%0b sel=%0d exp 1/1", out_valid, sel); end
    tick();
    for (int i = 0; i < 2; i++) begin
      #1;
      total++; if (out_valid !== 1'b1 || ack !== 4'b0000) begin bad++; $display("FAIL drop_hold[%0d] valid=%0b ack=%b", i, out_valid, ack); end
      tick();
    end
    out_ready = 1'b1;
    #1;
    total++; if (ack !== 4'b0010) begin bad++; $display("FAIL drop_ack got=%b exp=0010", ack); end
    total++; if (out_data !== 32'hCAFE0001) begin bad++; $display("FAIL drop_data got=%h exp=cafe0001", out_data); end
    tick();
    #1;
    total++; if (out_valid !== 1'b0 || ack !== 4'b0000) begin bad++; $display("FAIL drop_idle valid=%0b ack=%b", out_valid, ack); end
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    req = 4'b1000; d[3] = 32'h33333333; out_ready = 1'b0;
    tick();
    #1;
    total++; if (out_valid !== 1'b1 || sel !== 2'd3) begin bad++; $display("FAIL rmh_grant valid=%0b sel=%0d exp 1/3", out_valid, sel); end
    reset = 1'b1; out_ready = 1'b1; req = 4'b1111;
    #1;
    total++; if (ack !== 4'b0000) begin bad++; $display("FAIL rmh_ack got=%b exp=0000", ack); end
    tick();
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmh_valid got=%0b exp=0", out_valid); end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) d[i] = 32'hA0 + 32'(i);
    tick();
    #1;
    total++; if (out_valid !== 1'b1 || sel !== 2'd0 || out_data !== 32'hA0) begin bad++; $display("FAIL rmh_first valid=%0b sel=%0d data=%h exp 1/0/a0", out_valid, sel, out_data); end
    req = 4'b0000;
    tick();
  endtask

  // Behavioural model: one held word, a round-robin pointer, scan by arithmetic.
  task automatic test_random();
    bit          m_valid;
    int          m_sel, m_last;
    logic [31:0] m_data;
    logic [3:0]  exp_ack, cand;
    int          w;
    do_reset();
    m_valid = 1'b0; m_sel = 0; m_last = 3; m_data = 32'h0;
    for (int c = 0; c < 400; c++) begin
      req       = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) d[i] = $urandom;
      #1;
      exp_ack = (m_valid && out_ready) ? 4'(1 << m_sel) : 4'b0000;
      total++; if (out_valid !== m_valid || busy !== m_valid) begin bad++; $display("FAIL rnd_valid[%0d] got=%0b/%0b exp=%0b", c, out_valid, busy, m_valid); end
      total++; if (sel !== 2'(m_sel)) begin bad++; $display("FAIL rnd_sel[%0d] got=%0d exp=%0d", c, sel, m_sel); end
      total++; if (out_data !== m_data) begin bad++; $display("FAIL rnd_data[%0d] got=%h exp=%h", c, out_data, m_data); end
      total++; if (ack !== exp_ack) begin bad++; $display("FAIL rnd_ack[%0d] got=%b exp=%b", c, ack, exp_ack); end
      cand = req & ~exp_ack;
      if (!m_valid || out_ready) begin
        w = -1;
        for (int k = 1; k <= 4; k++) begin
          if (w < 0 && cand[(m_last + k) % 4]) w = (m_last + k) % 4;
        end
        if (w >= 0) begin
          m_valid = 1'b1; m_sel = w; m_last = w; m_data = d[w];
        end else begin
          m_valid = 1'b0;
        end
      end
      tick();
    end
  endtask

  initial begin
    reset = 1'b1; req = '0; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) d[i] = '0;
    @(negedge clk);
    test_reset();
    test_single();
    test_all();
    test_backpressure();
    test_drop();
    test_reset_mid_hold();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
